// File: rtl/spec_buffer_arbiter.sv
// spec_buffer_arbiter: fixed-priority burst arbiter sharing a dual-port spectrum RAM among four requesters
module spec_buffer_arbiter #(
  parameter int AddrWidth     = 14,
  parameter int DataWidth     = 32,
  parameter int RdLatency     = 2,
  parameter int MaxWaitCycles = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [3:0]             req_i,
  input  logic [3:0]             done_i,
  input  logic [3:0]             rd_en_i,
  input  logic [4*AddrWidth-1:0] rd_addr_i,
  input  logic [3:0]             wr_en_i,
  input  logic [4*AddrWidth-1:0] wr_addr_i,
  input  logic [4*DataWidth-1:0] wr_data_i,
  output logic [3:0]             gnt_o,
  output logic [1:0]             owner_o,
  output logic                   busy_o,
  output logic                   dpram_wea_o,
  output logic [AddrWidth-1:0]   dpram_addra_o,
  output logic [DataWidth-1:0]   dpram_dina_o,
  output logic [AddrWidth-1:0]   dpram_addrb_o,
  input  logic [DataWidth-1:0]   dpram_doutb_i,
  output logic [DataWidth-1:0]   rd_data_o,
  output logic [3:0]             rd_valid_o,
  output logic                   starve_o,
  output logic                   illegal_o
);
  localparam int CW = $clog2(MaxWaitCycles + 1);
  localparam int DW = $clog2(RdLatency + 2);
  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;
  state_t state, state_d;
  logic [1:0] sel;
  logic [3:0] own_mask;
  logic burst_end, own_rd, own_wr, wait_inc;
  logic [DW-1:0] drain_q;
  logic [CW-1:0] wait_q;
  logic [RdLatency:0] pv;
  logic [RdLatency:0][1:0] pid;
  always_comb begin
    sel = req_i[0] ? 2'd0 : req_i[1] ? 2'd1 : req_i[2] ? 2'd2 : 2'd3;
    own_mask = 4'b1 << owner_o;
    burst_end = done_i[owner_o] | ~req_i[owner_o];
    own_rd = state == GRANT && rd_en_i[owner_o];
    own_wr = state == GRANT && wr_en_i[owner_o];
    wait_inc = req_i[0] & ~gnt_o[0];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      owner_o <= '0;
      drain_q <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && |req_i) owner_o <= sel;
      drain_q <= state == DRAIN ? drain_q + 1'b1 : '0;
    end
  end
  always_comb
    state_d = state == IDLE  ? (|req_i ? GRANT : IDLE) :
              state == GRANT ? (burst_end ? DRAIN : GRANT) :
              (drain_q == DW'(RdLatency) ? IDLE : DRAIN);
  always_comb begin
    gnt_o = state == GRANT ? own_mask : 4'b0;
    busy_o = state != IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dpram_wea_o <= 1'b0;
      dpram_addra_o <= '0;
      dpram_dina_o <= '0;
      dpram_addrb_o <= '0;
      rd_data_o <= '0;
      rd_valid_o <= '0;
      pv <= '0;
      pid <= '0;
      wait_q <= '0;
      starve_o <= 1'b0;
      illegal_o <= 1'b0;
    end else begin
      dpram_wea_o <= own_wr;
      if (own_wr) begin
        dpram_addra_o <= wr_addr_i[owner_o*AddrWidth +: AddrWidth];
        dpram_dina_o <= wr_data_i[owner_o*DataWidth +: DataWidth];
      end
      if (own_rd) dpram_addrb_o <= rd_addr_i[owner_o*AddrWidth +: AddrWidth];
      pv <= {pv[RdLatency-1:0], own_rd};
      pid <= {pid[RdLatency-1:0], owner_o};
      rd_data_o <= dpram_doutb_i;
      rd_valid_o <= pv[RdLatency] ? 4'b1 << pid[RdLatency] : 4'b0;
      wait_q <= gnt_o[0] ? '0 : (wait_inc && wait_q != CW'(MaxWaitCycles)) ? wait_q + 1'b1 : wait_q;
      starve_o <= starve_o | (wait_inc && wait_q == CW'(MaxWaitCycles - 1));
      illegal_o <= illegal_o | (state == GRANT && |((rd_en_i | wr_en_i) & ~own_mask));
    end
  end
endmodule

// File: tb/tb_spec_buffer_arbiter.sv
// tb_spec_buffer_arbiter: table and scoreboard driven check of spec_buffer_arbiter
module tb_spec_buffer_arbiter;
  localparam int AW = 14, DW = 32;
  logic clk = 1'b0, rst_i = 1'b1;
  logic [3:0] req_i = '0, done_i = '0, rd_en_i = '0, wr_en_i = '0;
  logic [4*AW-1:0] rd_addr_i = '0, wr_addr_i = '0;
  logic [4*DW-1:0] wr_data_i = '0;
  logic [3:0] gnt_o, rd_valid_o;
  logic [1:0] owner_o;
  logic busy_o, dpram_wea_o, starve_o, illegal_o;
  logic [AW-1:0] dpram_addra_o, dpram_addrb_o;
  logic [DW-1:0] dpram_dina_o, dpram_doutb_i, rd_data_o, ram_d1;
  spec_buffer_arbiter dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .done_i(done_i), .rd_en_i(rd_en_i),
    .rd_addr_i(rd_addr_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .gnt_o(gnt_o), .owner_o(owner_o), .busy_o(busy_o), .dpram_wea_o(dpram_wea_o),
    .dpram_addra_o(dpram_addra_o), .dpram_dina_o(dpram_dina_o), .dpram_addrb_o(dpram_addrb_o),
    .dpram_doutb_i(dpram_doutb_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .starve_o(starve_o), .illegal_o(illegal_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    ram_d1 <= 32'(dpram_addrb_o) + 32'd100;
    dpram_doutb_i <= ram_d1;
  end
  typedef struct {int due; logic [3:0] vld; logic [31:0] data;} rexp_t;
  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} wexp_t;
  typedef struct {logic [3:0] gnt; logic [1:0] own; logic busy; logic [3:0] req; logic [3:0] done;} vec_t;
  rexp_t rq[$];
  wexp_t wq[$];
  vec_t vt[19];
  int cyc = 0, n_chk = 0, n_err = 0, waited = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  task automatic tick();
    wexp_t we;
    rexp_t re;
    @(posedge clk);
    #1;
    cyc++;
    rd_en_i = '0;
    wr_en_i = '0;
    done_i = '0;
    if (wq.size() > 0) begin
      we = wq.pop_front();
      chk("wea", dpram_wea_o, 1);
      chk("addra", dpram_addra_o, we.a);
      chk("dina", dpram_dina_o, we.d);
    end else chk("wea_idle", dpram_wea_o, 0);
    if (rq.size() > 0 && rq[0].due == cyc) begin
      re = rq.pop_front();
      chk("rd_valid", rd_valid_o, re.vld);
      chk("rd_data", rd_data_o, re.data);
    end else chk("rd_valid_idle", rd_valid_o, 0);
  endtask
  task automatic rd(input int o, input logic [AW-1:0] a, input bit legal);
    rd_en_i[o] = 1'b1;
    rd_addr_i[o*AW +: AW] = a;
    if (legal) rq.push_back('{due: cyc + 4, vld: 4'(1 << o), data: 32'(a) + 32'd100});
  endtask
  task automatic wr(input int o, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit legal);
    wr_en_i[o] = 1'b1;
    wr_addr_i[o*AW +: AW] = a;
    wr_data_i[o*DW +: DW] = d;
    if (legal) wq.push_back('{a: a, d: d});
  endtask
  initial begin
    vt[0]  = '{4'b0000, 2'd0, 1'b0, 4'b1010, 4'b0000};
    vt[1]  = '{4'b0010, 2'd1, 1'b1, 4'b1011, 4'b0100};
    vt[2]  = '{4'b0010, 2'd1, 1'b1, 4'b1011, 4'b0000};
    vt[3]  = '{4'b0010, 2'd1, 1'b1, 4'b1011, 4'b0010};
    vt[4]  = '{4'b0000, 2'd1, 1'b1, 4'b1001, 4'b0000};
    vt[5]  = '{4'b0000, 2'd1, 1'b1, 4'b1001, 4'b0000};
    vt[6]  = '{4'b0000, 2'd1, 1'b1, 4'b1001, 4'b0000};
    vt[7]  = '{4'b0000, 2'd0, 1'b0, 4'b1001, 4'b0000};
    vt[8]  = '{4'b0001, 2'd0, 1'b1, 4'b1000, 4'b0001};
    vt[9]  = '{4'b0000, 2'd0, 1'b1, 4'b1000, 4'b0000};
    vt[10] = '{4'b0000, 2'd0, 1'b1, 4'b1000, 4'b0000};
    vt[11] = '{4'b0000, 2'd0, 1'b1, 4'b1000, 4'b0000};
    vt[12] = '{4'b0000, 2'd0, 1'b0, 4'b1000, 4'b0000};
    vt[13] = '{4'b1000, 2'd3, 1'b1, 4'b0000, 4'b0000};
    vt[14] = '{4'b0000, 2'd3, 1'b1, 4'b0000, 4'b1000};
    vt[15] = '{4'b0000, 2'd3, 1'b1, 4'b0000, 4'b0000};
    vt[16] = '{4'b0000, 2'd3, 1'b1, 4'b0000, 4'b0000};
    vt[17] = '{4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0001};
    vt[18] = '{4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000};
    tick();
    tick();
    chk("rst_gnt", gnt_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_owner", owner_o, 0);
    chk("rst_flags", {starve_o, illegal_o}, 0);
    chk("rst_addrb", dpram_addrb_o, 0);
    chk("rst_rd_data", rd_data_o, 0);
    rst_i = 1'b0;
    for (int i = 0; i < 19; i++) begin
      tick();
      chk($sformatf("vec%0d_gnt", i), gnt_o, vt[i].gnt);
      chk($sformatf("vec%0d_busy", i), busy_o, vt[i].busy);
      if (vt[i].busy) chk($sformatf("vec%0d_owner", i), owner_o, vt[i].own);
      req_i = vt[i].req;
      done_i = vt[i].done;
    end
    req_i = 4'b0010;
    tick();
    chk("rd_gnt", gnt_o, 4'b0010);
    rd(1, 14'h10, 1);
    tick();
    chk("addrb0", dpram_addrb_o, 14'h10);
    rd(1, 14'h11, 1);
    tick();
    chk("addrb1", dpram_addrb_o, 14'h11);
    rd(1, 14'h12, 1);
    done_i[1] = 1'b1;
    tick();
    chk("addrb2", dpram_addrb_o, 14'h12);
    chk("rd_done_gnt", gnt_o, 0);
    chk("rd_done_busy", busy_o, 1);
    req_i = 4'b0000;
    repeat (6) tick();
    chk("illegal_clean", illegal_o, 0);
    req_i = 4'b0001;
    tick();
    chk("wr_gnt", gnt_o, 4'b0001);
    wr(0, 14'h3FFF, 32'h0ABC, 1);
    wr(2, 14'h0001, 32'hDEAD, 0);
    rd(0, 14'h20, 1);
    tick();
    chk("illegal_set", illegal_o, 1);
    chk("addrb_rw", dpram_addrb_o, 14'h20);
    tick();
    chk("addra_hold", dpram_addra_o, 14'h3FFF);
    chk("dina_hold", dpram_dina_o, 32'h0ABC);
    req_i = 4'b0000;
    repeat (6) tick();
    req_i = 4'b1000;
    tick();
    chk("st_gnt", gnt_o, 4'b1000);
    req_i = 4'b1001;
    for (int k = 0; k < 2000; k++) begin
      tick();
      waited++;
      chk("no_preempt", gnt_o, 4'b1000);
      chk("starve", starve_o, 64'(waited >= 1024));
    end
    done_i[3] = 1'b1;
    tick();
    chk("st_drain_gnt", gnt_o, 0);
    chk("st_drain_busy", busy_o, 1);
    tick();
    tick();
    chk("st_drain_end", busy_o, 1);
    tick();
    chk("st_idle", {gnt_o, busy_o}, 0);
    tick();
    chk("st_gnt0", gnt_o, 4'b0001);
    chk("starve_sticky", starve_o, 1);
    req_i = 4'b0000;
    repeat (5) tick();
    req_i = 4'b0100;
    tick();
    chk("rs_gnt", gnt_o, 4'b0100);
    rd(2, 14'h30, 1);
    tick();
    rd(2, 14'h31, 1);
    tick();
    rst_i = 1'b1;
    req_i = 4'b0000;
    rq.delete();
    tick();
    chk("rs_gnt0", gnt_o, 0);
    chk("rs_busy", busy_o, 0);
    chk("rs_owner", owner_o, 0);
    chk("rs_starve", starve_o, 0);
    chk("rs_illegal", illegal_o, 0);
    chk("rs_addrb", dpram_addrb_o, 0);
    rst_i = 1'b0;
    repeat (8) tick();
    chk("rq_empty", rq.size(), 0);
    chk("wq_empty", wq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
